// File: rtl/ifu_prefetch.sv
// Instruction-fetch prefetch unit.
// Keeps several granted requests in flight on an in-order req/gnt/rvalid bus.
// Responses are buffered in a small FIFO that feeds the IF/ID register through
// a valid/ready handshake. The FIFO credit check guarantees that every
// outstanding response has a free slot waiting for it.
// A flush redirects fetch. Any responses still in flight are counted into a
// discard counter and dropped when they arrive. A request that is still waiting
// for its grant is never withdrawn; it is marked stale and discarded later.
// A bus error is tagged onto its instruction and halts further requests until
// the next flush.
module ifu_prefetch #(
    parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    output logic [31:0] instr_addr_o,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_err_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic        busy_o
);

    localparam int              CW      = $clog2(DEPTH + 1);
    localparam int              AW      = $clog2(DEPTH);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]   MAX_C   = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0]   ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   ZERO_C  = {CW{1'b0}};
    localparam logic [AW-1:0]   PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]   PTR_ZERO = {AW{1'b0}};
    localparam logic [31:0]     BOOT_PC = BOOT_ADDR & 32'hFFFF_FFFC;

    // Bus side state
    logic          req_r;
    logic [31:0]   addr_r;
    logic          stale_r;     // pending ungranted request was overtaken by a flush
    logic [CW-1:0] out_r;       // granted, not yet answered
    logic [CW-1:0] disc_r;      // in-flight responses still to be dropped
    logic [31:0]   req_pc_r;    // address of the next request to issue
    logic [31:0]   rsp_pc_r;    // address of the next response to be kept
    logic          halt_r;
    logic          busy_r;

    // FIFO state: entry = {err, pc, data}
    logic [64:0]   fifo_mem_r [DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [CW-1:0] cnt_r;
    logic          valid_r;

    // Next-state and event signals
    logic          fire_s;
    logic          hold_s;
    logic          drop_s;
    logic          push_s;
    logic          pop_s;
    logic          issue_s;
    logic [31:0]   flush_pc_s;
    logic [31:0]   pc_base_s;
    logic [CW-1:0] out_n_s;
    logic [CW-1:0] disc_n_s;
    logic [CW-1:0] cnt_n_s;
    logic [CW:0]   sum_s;
    logic          halt_n_s;
    logic          stale_n_s;
    logic [31:0]   rsp_pc_n_s;
    logic          req_n_s;
    logic [31:0]   addr_n_s;
    logic [31:0]   req_pc_n_s;
    logic [64:0]   head_s;

    // Bus events, counter updates, flush handling and next request decision
    always_comb begin
        fire_s     = req_r & instr_gnt_i;
        hold_s     = req_r & ~instr_gnt_i;
        drop_s     = instr_rvalid_i & (disc_r != ZERO_C);
        push_s     = instr_rvalid_i & (disc_r == ZERO_C) & ~flush_i;
        pop_s      = valid_r & inst_ready_i & ~flush_i;
        flush_pc_s = flush_addr_i & 32'hFFFF_FFFC;
        out_n_s    = out_r + (fire_s ? ONE_C : ZERO_C) - (instr_rvalid_i ? ONE_C : ZERO_C);

        if (flush_i) begin
            // everything still in flight after this edge is stale
            disc_n_s   = out_n_s;
            cnt_n_s    = ZERO_C;
            halt_n_s   = 1'b0;
            rsp_pc_n_s = flush_pc_s;
            stale_n_s  = hold_s;
            pc_base_s  = flush_pc_s;
        end else begin
            disc_n_s   = disc_r - (drop_s ? ONE_C : ZERO_C)
                                + ((fire_s & stale_r) ? ONE_C : ZERO_C);
            cnt_n_s    = cnt_r + (push_s ? ONE_C : ZERO_C) - (pop_s ? ONE_C : ZERO_C);
            halt_n_s   = halt_r | (push_s & instr_err_i);
            rsp_pc_n_s = push_s ? (rsp_pc_r + 32'd4) : rsp_pc_r;
            stale_n_s  = stale_r & ~fire_s;
            pc_base_s  = req_pc_r;
        end

        // credit check on the state that will hold once this edge has passed
        sum_s   = {1'b0, out_n_s} + {1'b0, cnt_n_s};
        issue_s = ~halt_n_s & (out_n_s < MAX_C) & (sum_s < {1'b0, DEPTH_C});

        if (hold_s) begin
            // an ungranted request keeps its address, even across a flush
            req_n_s    = 1'b1;
            addr_n_s   = addr_r;
            req_pc_n_s = pc_base_s;
        end else if (issue_s) begin
            req_n_s    = 1'b1;
            addr_n_s   = pc_base_s;
            req_pc_n_s = pc_base_s + 32'd4;
        end else begin
            req_n_s    = 1'b0;
            addr_n_s   = pc_base_s;
            req_pc_n_s = pc_base_s;
        end
    end

    // Bus-side and bookkeeping registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_r    <= 1'b0;
            addr_r   <= BOOT_PC;
            stale_r  <= 1'b0;
            out_r    <= ZERO_C;
            disc_r   <= ZERO_C;
            req_pc_r <= BOOT_PC;
            rsp_pc_r <= BOOT_PC;
            halt_r   <= 1'b0;
            busy_r   <= 1'b0;
            cnt_r    <= ZERO_C;
            valid_r  <= 1'b0;
        end else begin
            req_r    <= req_n_s;
            addr_r   <= addr_n_s;
            stale_r  <= stale_n_s;
            out_r    <= out_n_s;
            disc_r   <= disc_n_s;
            req_pc_r <= req_pc_n_s;
            rsp_pc_r <= rsp_pc_n_s;
            halt_r   <= halt_n_s;
            busy_r   <= (out_n_s != ZERO_C);
            cnt_r    <= cnt_n_s;
            valid_r  <= (cnt_n_s != ZERO_C);
        end
    end

    // FIFO storage and pointers; a flush empties it and ignores push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= 65'd0;
            end
            wptr_r <= PTR_ZERO;
            rptr_r <= PTR_ZERO;
        end else if (flush_i) begin
            wptr_r <= PTR_ZERO;
            rptr_r <= PTR_ZERO;
        end else begin
            if (push_s) begin
                fifo_mem_r[wptr_r] <= {instr_err_i, rsp_pc_r, instr_rdata_i};
                wptr_r             <= wptr_r + PTR_ONE;
            end else begin
                wptr_r <= wptr_r;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end else begin
                rptr_r <= rptr_r;
            end
        end
    end

    // Head-of-FIFO read
    always_comb begin
        head_s = fifo_mem_r[rptr_r];
    end

    assign instr_req_o  = req_r;
    assign instr_addr_o = addr_r;
    assign inst_o       = head_s[31:0];
    assign pc_o         = head_s[63:32];
    assign inst_err_o   = head_s[64];
    assign inst_valid_o = valid_r;
    assign busy_o       = busy_r;

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Parametrised instruction-fetch unit; the successor to the single-request fetch stage.
- Keeps up to MAX_OUTSTANDING granted requests in flight on the instr_req/gnt/rvalid bus.
- Buffers responses in a DEPTH-entry FIFO and presents them to the IF/ID register with a valid/ready handshake.
- Handles pipeline flushes, discards stale in-flight responses, and tags bus errors per instruction.

Parameters:
- BOOT_ADDR, 32'h00000000, fetch address after reset (bits [1:0] ignored).
- DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests; 1 to DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush_i  in  1  redirect fetch; takes priority over all other events.
- flush_addr_i  in  32  new fetch address; bits [1:0] forced to 0.
- instr_req_o  out  1  bus request.
- instr_gnt_i  in  1  bus grant.
- instr_rvalid_i  in  1  response valid; responses arrive in order.
- instr_addr_o  out  32  request address, word aligned.
- instr_rdata_i  in  32  response data.
- instr_err_i  in  1  response error; qualified by instr_rvalid_i.
- inst_o  out  32  instruction at FIFO head.
- pc_o  out  32  address of inst_o.
- inst_err_o  out  1  fetch error for head entry.
- inst_valid_o  out  1  FIFO head valid.
- inst_ready_i  in  1  consumer accepts head.
- busy_o  out  1  outstanding count non-zero.

Behaviour:
- Reset values:
  - instr_req_o=0, instr_addr_o=BOOT_ADDR.
  - inst_valid_o=0, inst_o=0, pc_o=0, inst_err_o=0, busy_o=0.
  - FIFO empty; outstanding=0, discard=0; req_pc=rsp_pc=BOOT_ADDR; err_halt=0.
  - Reset asserted mid-transaction abandons everything; responses arriving after reset release are ignored only if the bus guarantees none are pending. The system integrator guarantees the bus is reset together with this block.
- Credit rule: invariant outstanding + fifo_count <= DEPTH. Counters are $clog2(DEPTH+1) bits wide.
- Request issue: instr_req_o=1 when all of the following hold:
  - !err_halt
  - outstanding < MAX_OUTSTANDING
  - outstanding + fifo_count < DEPTH
  - !flush_i, or a request is already pending ungranted.
- Bus hold: once asserted, instr_req_o and instr_addr_o stay constant until instr_gnt_i=1. A flush never withdraws or alters an ungranted request.
- On grant:
  - outstanding += 1.
  - req_pc += 4 (wraps modulo 2^32).
  - If a flush occurred while the request was pending, the granted request is counted into discard.
- On rvalid:
  - outstanding -= 1.
  - If discard > 0: discard -= 1 and the data is dropped.
  - Otherwise push {instr_err_i, rsp_pc, instr_rdata_i} and rsp_pc += 4.
  - If instr_err_i=1 and not discarded, set err_halt; no new requests are issued until the next flush.
- Latency: an accepted rvalid appears on inst_valid_o in the next cycle (registered FIFO, no bypass). Best-case steady state delivers one instruction per cycle when MAX_OUTSTANDING >= 2.
- Output: inst_valid_o = !fifo_empty. Pop on inst_valid_o && inst_ready_i. Push and pop in the same cycle are allowed at any level; full+push cannot occur because of the credit rule.
- Flush (cycle where flush_i=1):
  - FIFO cleared, so inst_valid_o=0 next cycle.
  - discard <= outstanding, taking this cycle's gnt and rvalid into account.
  - req_pc and rsp_pc <= flush_addr_i & ~3; err_halt cleared.
  - Push and pop in the flush cycle are ignored.
  - New requests start the following cycle, or after the pending ungranted request is granted.
- Simultaneous gnt+rvalid: outstanding unchanged. Flush+rvalid with discard>0: the rvalid consumes one discard first, then the remainder is reloaded as described above.
- busy_o = (outstanding != 0), registered.

Test Plan:
- Reset release, BOOT_ADDR=0x80, gnt/rvalid always 1 next cycle:
  - Addresses 0x80, 0x84, 0x88… are requested.
  - inst_valid_o rises 2 cycles after the first gnt.
  - pc_o matches in sequence; throughput reaches 1/cycle.
- inst_ready_i=0 with DEPTH=4: at most 4 requests are granted, then instr_req_o=0. Raising ready for one cycle produces exactly one new request.
- Delayed gnt (3 cycles) with flush_i pulsed on the second wait cycle, flush_addr=0x200:
  - instr_addr_o holds its old value until gnt.
  - That response is dropped.
  - The next request is 0x200; the first pc_o after the flush is 0x200.
- Flush with 2 responses outstanding (MAX_OUTSTANDING=2), flush_addr=0x1003: both responses are discarded; the next fetch is 0x1000; busy_o clears after the second rvalid.
- rvalid with instr_err_i=1 at pc 0x84: entry emitted with inst_err_o=1; instr_req_o stays 0 until a flush to 0x300, after which fetch resumes at 0x300 with inst_err_o=0.
- Fetch from 0xFFFFFFFC: the next address wraps to 0x00000000; pc_o=0x00000000 follows 0xFFFFFFFC.
